anc_nlms_engine: RTL and testbench
==================================

ANC_NLMS_ENGINE -- requirements
Module: anc_nlms_engine

Interface
REQ-001 SHALL have parameter N_TAPS, default 64: filter length; power of two, 8..256.
REQ-002 SHALL have parameter DATA_W, default 16: sample width, signed.
REQ-003 SHALL have parameter COEFF_W, default 18: coefficient width, signed, COEFF_W-2 fractional bits.
REQ-004 SHALL have parameter MU_SHIFT, default 6: base step size, mu = 2^-MU_SHIFT.
REQ-005 SHALL have port clk_in  input  1: sole clock, rising edge.
REQ-006 SHALL have port rst_in  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port ready_in  input  1: one-cycle pulse, new sample pair valid.
REQ-008 SHALL have port ref_in  input  DATA_W: reference (noise) sample.
REQ-009 SHALL have port err_in  input  DATA_W: error-mic sample, residual after previous output.
REQ-010 SHALL have port adapt_en  input  1: 1 = update coefficients, 0 = frozen.
REQ-011 SHALL have port bypass_in  input  1: 1 = force y_out to 0, processing continues.
REQ-012 SHALL have port y_out  output  DATA_W: anti-noise output, registered.
REQ-013 SHALL have port done_out  output  1: one-cycle pulse, y_out updated.
REQ-014 SHALL have port busy_out  output  1: high in every state except IDLE.
REQ-015 SHALL have port overrun_out  output  1: sticky; set when ready_in is dropped.

Function
REQ-016 SHALL use FSM IDLE -> UPDATE -> WRITE -> FILTER -> OUT -> IDLE; UPDATE skipped (IDLE -> WRITE) when adapt_en=0 at accept.
REQ-017 In IDLE, ready_in=1 SHALL latch ref_in, err_in, adapt_en, bypass_in; this is cycle 0.
REQ-018 ready_in while busy_out=1 SHALL be ignored and SHALL set overrun_out; no other state changes.
REQ-019 UPDATE SHALL last N_TAPS cycles, one tap k per cycle: w[k] += sat((e*x[n-1-k]) >>> (MU_SHIFT+s)), x from buffer before the new sample is written.
REQ-020 s SHALL be the bit index of the leading one of norm, minus (DATA_W-1), clamped to >= 0; norm=0 gives s=0.
REQ-021 Updated coefficients SHALL saturate to [-2^(COEFF_W-1), 2^(COEFF_W-1)-1]; no wrap.
REQ-022 WRITE (1 cycle) SHALL store ref at circular pointer, advance pointer modulo N_TAPS (wrap N_TAPS-1 -> 0), set norm += ref^2 - evicted^2.
REQ-023 norm SHALL be unsigned, 2*DATA_W + log2(N_TAPS) bits, exact, never negative.
REQ-024 FILTER SHALL last N_TAPS cycles, one MAC per cycle, acc = sum w[k]*x[n-k], accumulator width DATA_W+COEFF_W+log2(N_TAPS).
REQ-025 OUT SHALL register y_out = sat_DATA_W(-(acc >>> (COEFF_W-2))), or 0 if latched bypass=1, and pulse done_out.
REQ-026 done_out SHALL be high in cycle 2*N_TAPS+3 (adapt) or N_TAPS+3 (frozen) after ready_in; y_out holds until next OUT.
REQ-027 ready_in in the cycle done_out is high SHALL be accepted (state is IDLE).

Reset
REQ-028 rst_in=1 SHALL, at the next edge: state IDLE, all coefficients 0, buffer 0, pointer 0, norm 0, y_out 0, done_out 0, overrun_out 0.
REQ-029 Reset mid-operation SHALL abandon the sample; no partial coefficient update survives.
REQ-030 rst_in SHALL dominate ready_in in the same cycle.

Structure
REQ-031 Package anc_pkg SHALL hold the state enum and the saturate helper function.
REQ-032 Sub-module anc_lod (leading-one detector yielding s) SHALL be used; buffer and coefficients SHALL infer single-port-per-cycle RAM.

Verification
REQ-033 Reset, then ready_in with ref=0, err=0 -> done_out at cycle 2N+3, y_out=0, coefficients all 0.
REQ-034 N=8, adapt_en=0, w preloaded via adaptation to known values, impulse ref=16384 -> successive y_out equal -w[k]*16384 scaled, k=0..7.
REQ-035 ref=16384, err=16384 constant, adapt_en=1 -> w[0] increases monotonically and saturates at 2^(COEFF_W-1)-1, never wraps.
REQ-036 ready_in at cycle 5 of processing -> ignored, overrun_out=1 until reset, done_out still at cycle 2N+3.
REQ-037 10*N samples ref=1000 -> norm = N*10^6 after pointer wraps; bypass_in=1 -> y_out=0, done_out still pulses.
REQ-038 rst_in at cycle N+4 -> IDLE next cycle, all coefficients 0, no done_out.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared types and helpers for the NLMS active-noise-cancellation engine.
package anc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UPDATE = 3'd1,
    WRITE  = 3'd2,
    FILTER = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam int unsigned SAT_W = 64;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                  input int unsigned              w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/anc_nlms_engine_if.sv
// Sample-in / anti-noise-out handshake bundle of the NLMS engine.
interface anc_nlms_engine_if #(
  parameter int unsigned DATA_W = 16
);
  logic                     ready_in;
  logic signed [DATA_W-1:0] ref_in;
  logic signed [DATA_W-1:0] err_in;
  logic                     adapt_en;
  logic                     bypass_in;
  logic signed [DATA_W-1:0] y_out;
  logic                     done_out;
  logic                     busy_out;
  logic                     overrun_out;

  modport master (
    output ready_in, ref_in, err_in, adapt_en, bypass_in,
    input  y_out, done_out, busy_out, overrun_out
  );

  modport slave (
    input  ready_in, ref_in, err_in, adapt_en, bypass_in,
    output y_out, done_out, busy_out, overrun_out
  );
endinterface

// File: rtl/anc_lod.sv
// Leading-one detector: step-size normalisation shift derived from the power estimate.
module anc_lod #(
  parameter int unsigned IN_W = 38,
  parameter int unsigned BASE = 15,
  parameter int unsigned S_W  = 6
) (
  input  logic [IN_W-1:0] value,
  output logic [S_W-1:0]  s_c
);

  // Highest set bit above BASE wins; anything at or below BASE means no extra shift.
  always_comb begin
    s_c = '0;
    for (int unsigned i = BASE + 1; i < IN_W; i++) begin
      if (value[i]) s_c = S_W'(i - BASE);
    end
  end

endmodule

// File: rtl/anc_nlms_engine.sv
// Normalised-LMS adaptive FIR: per sample, optional coefficient update, history write,
// then a serial MAC producing the negated (anti-noise) output.
module anc_nlms_engine
  import anc_pkg::*;
#(
  parameter int unsigned N_TAPS   = 64,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEFF_W  = 18,
  parameter int unsigned MU_SHIFT = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  anc_nlms_engine_if.slave bus
);

  localparam int unsigned AW     = $clog2(N_TAPS);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned NORM_W = 2 * DATA_W + AW;
  localparam int unsigned ACC_W  = DATA_W + COEFF_W + AW;
  localparam int unsigned S_W    = $clog2(NORM_W);

  state_t                     state;
  logic [AW-1:0]              k_q;
  logic [AW-1:0]              ptr_q;
  logic [NORM_W-1:0]          norm_q;
  logic signed [DATA_W-1:0]   ref_q;
  logic signed [DATA_W-1:0]   err_q;
  logic                       adapt_q;
  logic                       bypass_q;
  logic [S_W-1:0]             s_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   y_q;
  logic                       done_q;
  logic                       busy_q;
  logic                       overrun_q;

  logic signed [COEFF_W-1:0]  coeff [N_TAPS];
  logic signed [DATA_W-1:0]   xbuf  [N_TAPS];

  logic [S_W-1:0]             s_c;
  logic [AW-1:0]              idx_c;
  logic signed [DATA_W-1:0]   x_c;
  logic signed [DATA_W-1:0]   ev_c;
  logic signed [COEFF_W-1:0]  w_c;
  logic signed [PROD_W-1:0]   eprod_c;
  logic signed [PROD_W-1:0]   step_c;
  logic signed [COEFF_W-1:0]  wnew_c;
  logic signed [ACC_W-1:0]    mac_c;
  logic signed [DATA_W-1:0]   y_c;
  logic signed [PROD_W-1:0]   ref_sq_c;
  logic signed [PROD_W-1:0]   ev_sq_c;
  logic [NORM_W-1:0]          norm_next_c;

  anc_lod #(
    .IN_W (NORM_W),
    .BASE (DATA_W - 1),
    .S_W  (S_W)
  ) u_lod (
    .value (norm_q),
    .s_c   (s_c)
  );

  // Same tap addressing serves both phases: before WRITE it yields x[n-1-k],
  // after the pointer advance it yields x[n-k].
  assign idx_c = ptr_q - AW'(1) - k_q;
  assign x_c   = xbuf[idx_c];
  assign w_c   = coeff[k_q];
  assign ev_c  = xbuf[ptr_q];

  assign eprod_c = PROD_W'(err_q) * PROD_W'(x_c);
  assign step_c  = eprod_c >>> (MU_SHIFT + 32'(s_q));
  assign wnew_c  = COEFF_W'(sat(SAT_W'(w_c) + SAT_W'(step_c), COEFF_W));

  assign mac_c = ACC_W'(w_c) * ACC_W'(x_c);
  assign y_c   = DATA_W'(sat(-(SAT_W'(acc_q) >>> (COEFF_W - 2)), DATA_W));

  // Sliding-window power: the evicted sample is always part of norm, so this never underflows.
  assign ref_sq_c    = PROD_W'(ref_q) * PROD_W'(ref_q);
  assign ev_sq_c     = PROD_W'(ev_c) * PROD_W'(ev_c);
  assign norm_next_c = norm_q + NORM_W'($unsigned(ref_sq_c)) - NORM_W'($unsigned(ev_sq_c));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < N_TAPS; i++) coeff[i] <= '0;
    end else if (state == UPDATE) begin
      coeff[k_q] <= wnew_c;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < N_TAPS; i++) xbuf[i] <= '0;
    end else if (state == WRITE) begin
      xbuf[ptr_q] <= ref_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      k_q       <= '0;
      ptr_q     <= '0;
      norm_q    <= '0;
      ref_q     <= '0;
      err_q     <= '0;
      adapt_q   <= 1'b0;
      bypass_q  <= 1'b0;
      s_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.ready_in && (state != IDLE)) overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.ready_in) begin
            ref_q    <= bus.ref_in;
            err_q    <= bus.err_in;
            adapt_q  <= bus.adapt_en;
            bypass_q <= bus.bypass_in;
            s_q      <= s_c;
            k_q      <= '0;
            busy_q   <= 1'b1;
            state    <= bus.adapt_en ? UPDATE : WRITE;
          end
        end
        UPDATE: begin
          k_q <= k_q + AW'(1);
          if (k_q == AW'(N_TAPS - 1)) state <= WRITE;
        end
        WRITE: begin
          ptr_q  <= ptr_q + AW'(1);
          norm_q <= norm_next_c;
          acc_q  <= '0;
          k_q    <= '0;
          state  <= FILTER;
        end
        FILTER: begin
          acc_q <= acc_q + mac_c;
          k_q   <= k_q + AW'(1);
          if (k_q == AW'(N_TAPS - 1)) state <= OUT;
        end
        OUT: begin
          y_q    <= bypass_q ? '0 : y_c;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.y_out       = y_q;
  assign bus.done_out    = done_q;
  assign bus.busy_out    = busy_q;
  assign bus.overrun_out = overrun_q;

endmodule

// File: tb/tb_anc_nlms_engine.sv
// Directed scoreboard bench for anc_nlms_engine against a shift-register reference model.
module tb_anc_nlms_engine;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 18;
  localparam int unsigned MU = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  anc_nlms_engine_if #(.DATA_W(DW)) bus ();

  anc_nlms_engine #(
    .N_TAPS   (N),
    .DATA_W   (DW),
    .COEFF_W  (CW),
    .MU_SHIFT (MU)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  longint mw [N];
  longint mh [N];
  longint mnorm;

  typedef struct {
    longint y;
    int     lat;
  } exp_t;
  exp_t sb [$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint clampv(input longint v, input int w);
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mw[i] = 0;
      mh[i] = 0;
    end
    mnorm = 0;
  endtask

  // mh[0] is the newest sample; power is recomputed from scratch every time.
  function automatic longint model_sample(input longint r, input longint e, input bit adapt,
                                          input bit byp);
    longint acc;
    int     msb;
    int     s;
    if (adapt) begin
      msb = -1;
      for (int b = 0; b < 63; b++) if (((mnorm >> b) & 1) != 0) msb = b;
      s = (msb > int'(DW) - 1) ? msb - (int'(DW) - 1) : 0;
      for (int k = 0; k < N; k++)
        mw[k] = clampv(mw[k] + ((e * mh[k]) >>> (int'(MU) + s)), CW);
    end
    for (int j = N - 1; j > 0; j--) mh[j] = mh[j-1];
    mh[0] = r;
    mnorm = 0;
    acc   = 0;
    for (int k = 0; k < N; k++) begin
      mnorm += mh[k] * mh[k];
      acc   += mw[k] * mh[k];
    end
    if (byp) return 0;
    return clampv(-(acc >>> (CW - 2)), DW);
  endfunction

  task automatic do_reset(input bit ready_during);
    @(negedge clk);
    rst = 1'b1;
    bus.ready_in = ready_during;
    bus.adapt_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.ready_in = 1'b0;
    model_reset();
  endtask

  // Drive one sample; optionally a stray ready pulse at cycle dup_at, optionally reuse the
  // current negedge (the done cycle of the previous sample) as cycle 0.
  task automatic run(input string tag, input longint r, input longint e, input bit adapt,
                     input bit byp, input int dup_at, input bit b2b);
    exp_t x;
    exp_t got_e;
    int   cyc;
    bit   got;
    x.y   = model_sample(r, e, adapt, byp);
    x.lat = adapt ? int'(2 * N + 3) : int'(N + 3);
    sb.push_back(x);
    if (!b2b) @(negedge clk);
    bus.ready_in  = 1'b1;
    bus.ref_in    = DW'(r);
    bus.err_in    = DW'(e);
    bus.adapt_en  = adapt;
    bus.bypass_in = byp;
    cyc = 0;
    got = 1'b0;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      cyc++;
      bus.ready_in = (cyc == dup_at);
      if (cyc == 1) check({tag, "_busy"}, longint'(bus.busy_out), 1);
      if (bus.done_out) got = 1'b1;
    end
    check({tag, "_done_seen"}, longint'(got), 1);
    got_e = sb.pop_front();
    check({tag, "_lat"}, cyc, got_e.lat);
    check({tag, "_y"}, bus.y_out, got_e.y);
  endtask

  initial begin
    int     cyc;
    bit     saw_done;
    longint prev;
    bus.ready_in  = 1'b0;
    bus.ref_in    = '0;
    bus.err_in    = '0;
    bus.adapt_en  = 1'b0;
    bus.bypass_in = 1'b0;

    do_reset(1'b0);
    @(negedge clk);
    check("rst_y", bus.y_out, 0);
    check("rst_done", longint'(bus.done_out), 0);
    check("rst_busy", longint'(bus.busy_out), 0);
    check("rst_overrun", longint'(bus.overrun_out), 0);

    run("zero", 0, 0, 1'b1, 1'b0, -1, 1'b0);
    for (int k = 0; k < N; k++) check($sformatf("zero_w%0d", k), dut.coeff[k], mw[k]);

    // Build nontrivial coefficients, flush history, then read them out with an impulse.
    begin
      longint rs [8] = '{3000, -2000, 1500, -500, 2500, 700, -1200, 900};
      longint es [8] = '{400, -300, 250, 100, -150, 350, -200, 50};
      for (int i = 0; i < 8; i++) run($sformatf("pre%0d", i), rs[i], es[i], 1'b1, 1'b0, -1, 1'b0);
    end
    for (int i = 0; i < N; i++) run($sformatf("flush%0d", i), 0, 0, 1'b0, 1'b0, -1, 1'b0);
    run("imp0", 16384, 0, 1'b0, 1'b0, -1, 1'b0);
    for (int i = 1; i < N; i++) run($sformatf("imp%0d", i), 0, 0, 1'b0, 1'b0, -1, 1'b0);

    run("b2b_a", 1234, 0, 1'b0, 1'b0, -1, 1'b0);
    run("b2b_b", -777, 0, 1'b0, 1'b0, -1, 1'b1);

    run("ovr", 100, 0, 1'b1, 1'b0, 5, 1'b0);
    check("ovr_set", longint'(bus.overrun_out), 1);
    run("ovr_next", 200, 0, 1'b0, 1'b0, -1, 1'b0);
    check("ovr_sticky", longint'(bus.overrun_out), 1);
    do_reset(1'b1);
    @(negedge clk);
    check("rst_dom_busy", longint'(bus.busy_out), 0);
    check("ovr_clear", longint'(bus.overrun_out), 0);

    prev = 0;
    for (int i = 0; i < 70; i++) begin
      run($sformatf("sat%0d", i), 16384, 16384, 1'b1, 1'b0, -1, 1'b0);
      check($sformatf("sat%0d_w0", i), dut.coeff[0], mw[0]);
      check($sformatf("sat%0d_mono", i), longint'(longint'(dut.coeff[0]) >= prev), 1);
      prev = dut.coeff[0];
    end
    check("sat_w0_max", dut.coeff[0], 131071);

    for (int i = 0; i < 10 * N; i++) run($sformatf("pw%0d", i), 1000, 0, 1'b0, 1'b0, -1, 1'b0);
    check("norm_model", longint'(dut.norm_q), mnorm);
    check("norm_value", longint'(dut.norm_q), 8000000);
    run("byp_frozen", 1000, 0, 1'b0, 1'b1, -1, 1'b0);
    run("byp_adapt", 1000, 5, 1'b1, 1'b1, -1, 1'b0);
    run("unbyp", 1000, 0, 1'b0, 1'b0, -1, 1'b0);

    // Reset in the middle of a FILTER pass.
    @(negedge clk);
    bus.ready_in = 1'b1;
    bus.ref_in   = DW'(5000);
    bus.err_in   = DW'(3000);
    bus.adapt_en = 1'b1;
    cyc = 0;
    saw_done = 1'b0;
    while (cyc < int'(3 * N + 10)) begin
      @(negedge clk);
      cyc++;
      bus.ready_in = 1'b0;
      if (bus.done_out) saw_done = 1'b1;
      if (cyc == int'(N + 4)) rst = 1'b1;
      if (cyc == int'(N + 5)) begin
        rst = 1'b0;
        check("mid_rst_busy", longint'(bus.busy_out), 0);
      end
    end
    model_reset();
    check("mid_rst_no_done", longint'(saw_done), 0);
    check("mid_rst_y", bus.y_out, 0);
    check("mid_rst_norm", longint'(dut.norm_q), mnorm);
    for (int k = 0; k < N; k++) check($sformatf("mid_rst_w%0d", k), dut.coeff[k], mw[k]);
    run("post_rst", 16384, 0, 1'b0, 1'b0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
